// File: rtl/ni_injector.sv
// ni_injector: segments local core packet requests into stamped flits for the router local port;
// self-addressed packets are drained and flagged instead of injected.
module ni_injector #(
  parameter int CORD_X       = 1,
  parameter int CORD_Y       = 1,
  parameter int WIDTH_COORD  = 3,
  parameter int DATA_W       = 32,
  parameter int LEN_W        = 2,
  parameter int PKTID_W      = 4,
  parameter int STARVE_LIMIT = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [2*WIDTH_COORD-1:0] req_dst,
  input  logic [LEN_W-1:0]         req_len,
  input  logic                     data_valid,
  output logic                     data_ready,
  input  logic [DATA_W-1:0]        data_in,
  output logic                     flit_valid,
  input  logic                     flit_ready,
  output logic [2*WIDTH_COORD-1:0] flit_dst,
  output logic [2*WIDTH_COORD-1:0] flit_src,
  output logic [PKTID_W-1:0]       flit_pktid,
  output logic [LEN_W-1:0]         flit_seq,
  output logic                     flit_head,
  output logic                     flit_tail,
  output logic [DATA_W-1:0]        flit_data,
  output logic                     drop_self,
  output logic                     starve
);
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [2*WIDTH_COORD-1:0] SELF = {WIDTH_COORD'(CORD_Y), WIDTH_COORD'(CORD_X)};
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, LOAD, SEND, DRAIN} state_t;

  state_t                   state, state_nx;
  logic [2*WIDTH_COORD-1:0] dst;
  logic [LEN_W-1:0]         len, seq;
  logic [PKTID_W-1:0]       pktid, pkt_cnt;
  logic [DATA_W-1:0]        data;
  logic [CW-1:0]            stall, stall_nx;
  logic                     drop_q, starve_q;
  logic                     accept, is_self, is_tail, take;

  assign req_ready  = state == IDLE && !reset;
  assign accept     = req_valid && req_ready;
  assign is_self    = req_dst == SELF;
  assign is_tail    = seq == len;
  assign flit_valid = state == SEND;
  // In SEND the next word may only be taken alongside the current flit's acceptance.
  assign data_ready = state == LOAD || state == DRAIN || (flit_valid && flit_ready && !is_tail);
  assign take       = data_valid && data_ready;
  assign stall_nx   = (flit_valid && !flit_ready) ? (stall == LIMIT ? stall : stall + 1'b1) : '0;

  assign flit_dst   = dst;
  assign flit_src   = SELF;
  assign flit_pktid = pktid;
  assign flit_seq   = seq;
  assign flit_head  = seq == '0;
  assign flit_tail  = is_tail;
  assign flit_data  = data;
  assign drop_self  = drop_q;
  assign starve     = starve_q;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = accept ? (is_self ? DRAIN : LOAD) : IDLE;
      LOAD:    state_nx = data_valid ? SEND : LOAD;
      SEND:    state_nx = !flit_ready ? SEND : is_tail ? IDLE : data_valid ? SEND : LOAD;
      DRAIN:   state_nx = (data_valid && is_tail) ? IDLE : DRAIN;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      dst      <= '0;
      len      <= '0;
      seq      <= '0;
      pktid    <= '0;
      pkt_cnt  <= '0;
      data     <= '0;
      stall    <= '0;
      drop_q   <= 1'b0;
      starve_q <= 1'b0;
    end else begin
      state    <= state_nx;
      drop_q   <= accept && is_self;
      stall    <= stall_nx;
      starve_q <= stall_nx == LIMIT;
      if (accept) begin
        dst <= req_dst;
        len <= req_len;
        seq <= '0;
      end
      if (accept && !is_self) begin
        pktid   <= pkt_cnt;
        pkt_cnt <= pkt_cnt + 1'b1;
      end
      if (take && state != DRAIN) data <= data_in;
      if ((flit_valid && flit_ready && !is_tail) || (state == DRAIN && data_valid && !is_tail))
        seq <= seq + 1'b1;
    end
  end
endmodule

// File: tb/tb_ni_injector.sv
// tb_ni_injector: table-driven packets checked through a flit scoreboard, plus hand-written
// sequences for starvation, pktid wrap, mid-packet reset and injection latency.
module tb_ni_injector;
  logic        clk = 0, reset = 1;
  logic        req_valid = 0, req_ready;
  logic [5:0]  req_dst = '0;
  logic [1:0]  req_len = '0;
  logic        data_valid = 0, data_ready;
  logic [31:0] data_in = '0;
  logic        flit_valid, flit_ready = 1;
  logic [5:0]  flit_dst, flit_src;
  logic [3:0]  flit_pktid;
  logic [1:0]  flit_seq;
  logic        flit_head, flit_tail;
  logic [31:0] flit_data;
  logic        drop_self, starve;

  ni_injector dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_dst(req_dst),
    .req_len(req_len), .data_valid(data_valid), .data_ready(data_ready), .data_in(data_in),
    .flit_valid(flit_valid), .flit_ready(flit_ready), .flit_dst(flit_dst), .flit_src(flit_src),
    .flit_pktid(flit_pktid), .flit_seq(flit_seq), .flit_head(flit_head), .flit_tail(flit_tail),
    .flit_data(flit_data), .drop_self(drop_self), .starve(starve)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0]  dst;
    logic [5:0]  src;
    logic [3:0]  pktid;
    logic [1:0]  seq;
    logic        head;
    logic        tail;
    logic [31:0] data;
  } flit_t;

  typedef struct {
    logic [5:0] dst;
    logic [1:0] len;
    int         gap;
    logic [3:0] pktid;
    bit         drop;
  } vec_t;

  flit_t q[$];
  int    total = 0, bad = 0, drop_cnt = 0;
  vec_t  tv[7];

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic fail(string name);
    total++;
    bad++;
    $display("FAIL %s: got timeout want handshake", name);
  endtask

  function automatic logic [31:0] wd(int b, int s);
    return 32'hC0DE_0000 + 32'(b * 16 + s);
  endfunction

  function automatic flit_t cur_flit();
    return '{flit_dst, flit_src, flit_pktid, flit_seq, flit_head, flit_tail, flit_data};
  endfunction

  function automatic flit_t mk(logic [5:0] dst, int len, logic [3:0] id, int s, int b);
    return '{dst, 6'b001_001, id, 2'(s), s == 0, s == len, wd(b, s)};
  endfunction

  task automatic push_pkt(logic [5:0] dst, int len, logic [3:0] id, int b);
    for (int s = 0; s <= len; s++) q.push_back(mk(dst, len, id, s, b));
  endtask

  always @(negedge clk) begin
    if (!reset && drop_self) drop_cnt++;
    if (!reset && flit_valid && flit_ready) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_flit: got %h want none", cur_flit());
      end else chk("flit", cur_flit(), q.pop_front());
    end
  end

  task automatic wait_idle();
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (q.size() == 0 && req_ready) return;
    end
    fail("idle_wait");
  endtask

  task automatic send_pkt(logic [5:0] dst, logic [1:0] len, int gap, logic [3:0] id, bit drop, int b);
    int d0;
    d0 = drop_cnt;
    if (!drop) push_pkt(dst, int'(len), id, b);
    @(posedge clk); #1;
    fork
      begin
        bit hs;
        hs = 0;
        req_valid = 1; req_dst = dst; req_len = len;
        for (int n = 0; n < 100 && !hs; n++) begin
          @(negedge clk); hs = req_ready;
          @(posedge clk); #1;
        end
        if (!hs) fail("req_wait");
        req_valid = 0;
      end
      begin
        bit hs;
        for (int s = 0; s <= int'(len); s++) begin
          data_valid = 1; data_in = wd(b, s); hs = 0;
          for (int n = 0; n < 100 && !hs; n++) begin
            @(negedge clk); hs = data_ready;
            @(posedge clk); #1;
          end
          if (!hs) fail("data_wait");
          data_valid = 0;
          repeat (gap) begin @(posedge clk); #1; end
        end
      end
    join
    wait_idle();
    chk("drop_pulses", 64'(drop_cnt - d0), drop ? 64'd1 : 64'd0);
  endtask

  initial begin
    flit_t ef;
    tv[0] = '{6'b010_011, 2'd2, 0, 4'd0, 1'b0};
    tv[1] = '{6'b001_001, 2'd1, 0, 4'd0, 1'b1};
    tv[2] = '{6'b000_000, 2'd3, 2, 4'd1, 1'b0};
    tv[3] = '{6'b011_010, 2'd3, 0, 4'd2, 1'b0};
    tv[4] = '{6'b001_000, 2'd0, 0, 4'd3, 1'b0};
    tv[5] = '{6'b001_001, 2'd0, 1, 4'd0, 1'b1};
    tv[6] = '{6'b111_111, 2'd1, 1, 4'd4, 1'b0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_flit_valid", flit_valid, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_data_ready", data_ready, 0);
    chk("rst_drop_self", drop_self, 0);
    chk("rst_starve", starve, 0);
    @(posedge clk); #1 reset = 0;

    for (int i = 0; i < 7; i++) send_pkt(tv[i].dst, tv[i].len, tv[i].gap, tv[i].pktid, tv[i].drop, i);

    ef = mk(6'b000_010, 0, 4'd5, 0, 50);
    q.push_back(ef);
    flit_ready = 0;
    @(posedge clk); #1 req_valid = 1; req_dst = 6'b000_010; req_len = 0; data_valid = 1; data_in = wd(50, 0);
    @(negedge clk); chk("starve_req_ready", req_ready, 1);
    @(posedge clk); #1 req_valid = 0;
    @(negedge clk); chk("starve_load_ready", data_ready, 1);
    @(posedge clk); #1 data_valid = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      chk($sformatf("stall_valid_%0d", k), flit_valid, 1);
      chk($sformatf("stall_fields_%0d", k), cur_flit(), ef);
      chk($sformatf("starve_%0d", k), starve, k >= 17);
    end
    @(posedge clk); #1 flit_ready = 1;
    @(negedge clk); chk("starve_on_release", starve, 1);
    @(negedge clk);
    chk("starve_cleared", starve, 0);
    chk("released_valid", flit_valid, 0);
    wait_idle();

    @(posedge clk); #1 reset = 1;
    @(posedge clk); #1 reset = 0;
    for (int i = 0; i < 17; i++) send_pkt(6'b000_010, 2'd0, 0, 4'(i % 16), 1'b0, 100 + i);

    push_pkt(6'b011_000, 3, 4'd1, 200);
    @(posedge clk); #1 req_valid = 1; req_dst = 6'b011_000; req_len = 3; data_valid = 1; data_in = wd(200, 0);
    @(negedge clk); chk("mid_req_ready", req_ready, 1);
    @(posedge clk); #1 req_valid = 0;
    @(posedge clk); #1 data_in = wd(200, 1);
    @(posedge clk); #1 data_in = wd(200, 2);
    @(posedge clk); #1 reset = 1; flit_ready = 0; data_valid = 0;
    @(negedge clk);
    chk("mid_req_ready_in_reset", req_ready, 0);
    chk("mid_flits_left", 64'(q.size()), 2);
    @(posedge clk); #1 reset = 0;
    @(negedge clk);
    chk("post_rst_flit_valid", flit_valid, 0);
    chk("post_rst_data_ready", data_ready, 0);
    chk("post_rst_drop_self", drop_self, 0);
    chk("post_rst_starve", starve, 0);
    chk("post_rst_req_ready", req_ready, 1);
    q.delete();
    flit_ready = 1;

    push_pkt(6'b010_001, 0, 4'd0, 300);
    @(posedge clk); #1 req_valid = 1; req_dst = 6'b010_001; req_len = 0; data_valid = 1; data_in = wd(300, 0);
    @(negedge clk);
    chk("lat0_flit_valid", flit_valid, 0);
    chk("lat0_data_ready", data_ready, 0);
    @(posedge clk); #1 req_valid = 0;
    @(negedge clk);
    chk("lat1_flit_valid", flit_valid, 0);
    chk("lat1_data_ready", data_ready, 1);
    @(posedge clk); #1 data_valid = 0;
    @(negedge clk);
    chk("lat2_flit_valid", flit_valid, 1);
    chk("lat2_pktid", flit_pktid, 0);
    chk("lat2_seq", flit_seq, 0);
    chk("lat2_head", flit_head, 1);
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
